serial_frame_deser: RTL and testbench
=====================================

# serial_frame_deser

Deserializer placed directly downstream of the 4-stage bit delay chain. It consumes the delayed serial bit stream, hunts for a sync word, then assembles a fixed number of payload bytes MSB-first. It emits each byte with a one-cycle valid strobe and flags the first and last byte of every frame. It returns to hunting after each frame or on request.

## Interface
- SYNC_WORD, 8'hA5, sync pattern; bits arrive MSB-first.
- PAYLOAD_BYTES, 4, bytes per frame after sync; legal range 1..255.

- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- i_data  input  1  serial bit from the upstream delay chain.
- i_bit_valid  input  1  qualifies i_data; when low, no state advances.
- i_resync  input  1  synchronous request to abandon the current frame and re-hunt.
- o_byte  output  8  last assembled payload byte; holds until the next byte.
- o_byte_valid  output  1  one-cycle strobe; o_byte is new.
- o_frame_start  output  1  high with o_byte_valid on the first payload byte.
- o_frame_end  output  1  high with o_byte_valid on the last payload byte.
- o_sync_lock  output  1  high while in PAYLOAD state.
- o_frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

## Operation
- Reset (RST high, asynchronously) sets all outputs to 0. It clears the shift register, the fill counter, the bit counter and the byte counter, and sets state to HUNT.
- States:
  - HUNT: the shift register shifts sh <= {sh[6:0], i_data} on each valid bit. A 4-bit fill counter saturates at 8.
  - HUNT -> PAYLOAD: on the valid bit where the fill counter is already at 7 or more AND {sh[6:0], i_data} == SYNC_WORD.
  - Effect: a sync word needs 8 fresh bits since entering HUNT; it never matches on stale or cleared bits.
  - PAYLOAD: bits shift into the byte register MSB-first. A 3-bit bit counter advances per valid bit.
  - On the 8th bit of a byte:
    - o_byte <= assembled byte, and o_byte_valid pulses.
    - o_frame_start is 1 if the byte counter is 0.
    - o_frame_end is 1 if the byte counter is PAYLOAD_BYTES-1.
    - The byte counter increments.
  - After the last byte: o_frame_cnt increments (mod 256) and state returns to HUNT with the fill counter and shift register cleared. Payload bits never contribute to a following sync match.
- PAYLOAD_BYTES == 1: the first byte carries both o_frame_start and o_frame_end.
- i_resync = 1 in any state:
  - Next state is HUNT; all counters and the shift register clear.
  - No byte is emitted that cycle, even if the 8th bit is valid.
  - o_frame_cnt is unchanged.
  - i_resync has priority over i_bit_valid.
- i_bit_valid = 0: state, counters and shift data hold. Strobes are 0.
- o_byte_valid, o_frame_start and o_frame_end are single-cycle. They are 0 in every cycle without a byte completion.
- o_sync_lock = 1 exactly while state == PAYLOAD. It is registered with the state.

## Timing
- All outputs are registered.
- Byte latency: o_byte/o_byte_valid are visible in the cycle after the rising edge that samples the byte's 8th valid bit.
- Sync latency: o_sync_lock rises in the cycle after the edge sampling the last sync bit.
- End of frame: o_sync_lock falls in the same cycle o_frame_end is seen. o_frame_cnt updates in that same cycle.
- With continuous valid bits:
  - Frame length on the wire is 8 + 8*PAYLOAD_BYTES cycles.
  - Back-to-back frames need no idle bits: the next frame's sync bits may start in the cycle after the last payload bit.
- Reset mid-frame: outputs are 0 immediately and asynchronously, with no partial byte. After release, the block requires a full 8-bit sync before any byte.

## Test plan
- Reset: hold RST high 3 cycles with random i_data/i_bit_valid -> all outputs 0; o_sync_lock stays 0 for the first 7 valid bits after release, regardless of data.
- Nominal frame: send A5 12 34 56 78 continuously, MSB-first -> o_byte_valid 4 times with bytes 0x12, 0x34, 0x56, 0x78. o_frame_start only with 0x12; o_frame_end only with 0x78; o_frame_cnt 0 -> 1; o_sync_lock high for 32 cycles.
- False sync / no overlap:
  - Send A4 then A5 00 00 00 00 -> lock only on A5.
  - Send a payload containing A5, then 0x5A -> no lock from payload bits.
- Valid gaps: the nominal frame with i_bit_valid low on random cycles (about 30%) -> identical byte sequence and strobes; no strobe in any gap cycle.
- Resync: assert i_resync on the 8th bit of byte 2 -> no byte 0x34 emitted; o_sync_lock 0 next cycle; o_frame_cnt unchanged. A following full A5 frame is received normally.
- Wrap and back-to-back: 256 consecutive frames with PAYLOAD_BYTES=1, no idle bits -> o_frame_cnt wraps to 0; every frame's byte carries both start and end; no missed sync.

Source files
------------

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: hunts for a sync word in a bit stream, then
// assembles PAYLOAD_BYTES bytes MSB-first with start/end-of-frame flags.
module serial_frame_deser #(
  parameter logic [7:0] SYNC_WORD     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_data,
  input  logic       i_bit_valid,
  input  logic       i_resync,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_start,
  output logic       o_frame_end,
  output logic       o_sync_lock,
  output logic [7:0] o_frame_cnt
);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  state_t     state, state_nxt;
  logic [7:0] sh;
  logic [3:0] fill;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;

  logic [7:0] shifted;
  logic       sync_hit, byte_done, last_byte;

  assign shifted   = {sh[6:0], i_data};
  // A match needs 8 fresh bits since entering HUNT, so stale bits never sync.
  assign sync_hit  = (state == HUNT) && i_bit_valid && !i_resync &&
                     (fill >= 4'd7) && (shifted == SYNC_WORD);
  assign byte_done = (state == PAYLOAD) && i_bit_valid && !i_resync &&
                     (bit_cnt == 3'd7);
  assign last_byte = byte_done && (byte_cnt == LAST_BYTE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_resync)       state_nxt = HUNT;
    else if (sync_hit)  state_nxt = PAYLOAD;
    else if (last_byte) state_nxt = HUNT;
  end

  assign o_sync_lock = (state == PAYLOAD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh            <= '0;
      fill          <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_byte_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      if (i_resync) begin
        sh       <= '0;
        fill     <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (i_bit_valid) begin
        if (state == HUNT) begin
          if (sync_hit) begin
            sh       <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end else begin
            sh <= shifted;
            if (fill != 4'd8) fill <= fill + 4'd1;
          end
        end else begin
          sh      <= shifted;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            o_byte        <= shifted;
            o_byte_valid  <= 1'b1;
            o_frame_start <= (byte_cnt == 8'd0);
            o_frame_end   <= last_byte;
            byte_cnt      <= byte_cnt + 8'd1;
            // Clearing here keeps payload bits out of the next sync hunt.
            if (last_byte) begin
              o_frame_cnt <= o_frame_cnt + 8'd1;
              sh          <= '0;
              fill        <= '0;
              byte_cnt    <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser: scoreboard of expected bytes,
// one DUT with 4-byte frames and one with 1-byte frames for counter wrap.
module tb_serial_frame_deser;

  typedef struct packed {
    logic [7:0] b;
    logic       s;
    logic       e;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       d0, v0, r0, d1, v1, r1;
  logic [7:0] b0, b1, cnt0, cnt1;
  logic       bv0, fs0, fe0, lk0, bv1, fs1, fe1, lk1;

  int   checks = 0;
  int   failures = 0;
  int   lock_cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic lv0 = 1'b0, lv1 = 1'b0;
  logic [7:0] sw = 8'hA5;

  serial_frame_deser #(.SYNC_WORD(8'hA5), .PAYLOAD_BYTES(4)) dut (
    .CLK(CLK), .RST(RST), .i_data(d0), .i_bit_valid(v0), .i_resync(r0),
    .o_byte(b0), .o_byte_valid(bv0), .o_frame_start(fs0), .o_frame_end(fe0),
    .o_sync_lock(lk0), .o_frame_cnt(cnt0)
  );

  serial_frame_deser #(.SYNC_WORD(8'hA5), .PAYLOAD_BYTES(1)) dut1 (
    .CLK(CLK), .RST(RST), .i_data(d1), .i_bit_valid(v1), .i_resync(r1),
    .o_byte(b1), .o_byte_valid(bv1), .o_frame_start(fs1), .o_frame_end(fe1),
    .o_sync_lock(lk1), .o_frame_cnt(cnt1)
  );

  always #5 CLK = ~CLK;

  // Remember whether the last edge saw a usable bit, to catch gap strobes.
  always @(posedge CLK) begin
    lv0 <= v0 & ~r0;
    lv1 <= v1 & ~r1;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (lk0) lock_cyc++;
    checks++;
    assert (bv0 || !(fs0 || fe0))
      else begin failures++; $error("FAIL flag_no_strobe0 got=%0b%0b exp=00", fs0, fe0); end
    if (bv0 && !RST) begin
      checks++;
      assert (lv0 === 1'b1)
        else begin failures++; $error("FAIL gap_strobe0 got=1 exp=0"); end
      checks++;
      assert (q0.size() > 0)
        else begin failures++; $error("FAIL unexpected_byte0 got=%0h exp=none", b0); end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        assert ({b0, fs0, fe0} === {e.b, e.s, e.e})
          else begin failures++; $error("FAIL byte0 got=%0h/%0b%0b exp=%0h/%0b%0b", b0, fs0, fe0, e.b, e.s, e.e); end
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (bv1 && !RST) begin
      checks++;
      assert (lv1 === 1'b1)
        else begin failures++; $error("FAIL gap_strobe1 got=1 exp=0"); end
      checks++;
      assert (q1.size() > 0)
        else begin failures++; $error("FAIL unexpected_byte1 got=%0h exp=none", b1); end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        assert ({b1, fs1, fe1} === {e.b, e.s, e.e})
          else begin failures++; $error("FAIL byte1 got=%0h/%0b%0b exp=%0h/%0b%0b", b1, fs1, fe1, e.b, e.s, e.e); end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin failures++; $error("FAIL %s got=%0h exp=%0h", tag, obs, exp); end
  endtask

  // One bit period: drive on the falling edge, return just after the rising edge.
  task automatic drv(input int sel, input logic d, input logic v, input logic r);
    @(negedge CLK);
    if (sel == 0) begin d0 = d; v0 = v; r0 = r; end
    else          begin d1 = d; v1 = v; r1 = r; end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) while ($urandom_range(0, 9) < 3) drv(sel, 1'($urandom), 1'b0, 1'b0);
      drv(sel, b[i], 1'b1, 1'b0);
    end
  endtask

  task automatic frame0(input logic [31:0] p, input bit gaps);
    for (int k = 0; k < 4; k++) q0.push_back('{p[31-8*k -: 8], k == 0, k == 3});
    send_byte(0, 8'hA5, gaps);
    for (int k = 0; k < 4; k++) send_byte(0, p[31-8*k -: 8], gaps);
  endtask

  initial begin
    logic [7:0] a4 = 8'hA4;
    logic [7:0] b34 = 8'h34;
    logic [7:0] stale [2] = '{8'hB4, 8'h5A};
    RST = 1'b1;
    d0 = 0; v0 = 0; r0 = 0; d1 = 0; v1 = 0; r1 = 0;

    // Reset with random inputs: every output must read 0.
    repeat (3) begin
      @(negedge CLK);
      d0 = 1'($urandom); v0 = 1'($urandom); d1 = 1'($urandom); v1 = 1'($urandom);
      #1;
      chk("rst_out0", {12'h0, b0, bv0, fs0, fe0, lk0, cnt0}, 32'h0);
      chk("rst_out1", {12'h0, b1, bv1, fs1, fe1, lk1, cnt1}, 32'h0);
    end
    @(negedge CLK);
    RST = 1'b0; v0 = 0; v1 = 0;
    drv(0, 1'b0, 1'b0, 1'b0);
    lock_cyc = 0;

    // Nominal frame; no lock during the first 7 valid bits.
    q0.push_back('{8'h12, 1'b1, 1'b0});
    q0.push_back('{8'h34, 1'b0, 1'b0});
    q0.push_back('{8'h56, 1'b0, 1'b0});
    q0.push_back('{8'h78, 1'b0, 1'b1});
    for (int i = 7; i >= 1; i--) begin
      drv(0, sw[i], 1'b1, 1'b0);
      chk("lock_early", {31'h0, lk0}, 32'h0);
    end
    drv(0, sw[0], 1'b1, 1'b0);
    chk("lock_rise", {31'h0, lk0}, 32'h1);
    send_byte(0, 8'h12, 0); send_byte(0, 8'h34, 0);
    send_byte(0, 8'h56, 0); send_byte(0, 8'h78, 0);
    chk("frame_cnt_nom", {24'h0, cnt0}, 32'd1);
    chk("lock_fall_nom", {31'h0, lk0}, 32'h0);
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(0, 1'b0, 1'b0, 1'b0);
    chk("lock_cycles", lock_cyc, 32'd32);

    // False sync: A4 must not lock, A5 must.
    for (int i = 7; i >= 0; i--) begin
      drv(0, a4[i], 1'b1, 1'b0);
      chk("lock_a4", {31'h0, lk0}, 32'h0);
    end
    for (int k = 0; k < 4; k++) q0.push_back('{8'h00, k == 0, k == 3});
    for (int i = 7; i >= 1; i--) begin
      drv(0, sw[i], 1'b1, 1'b0);
      chk("lock_a5_part", {31'h0, lk0}, 32'h0);
    end
    drv(0, sw[0], 1'b1, 1'b0);
    chk("lock_a5", {31'h0, lk0}, 32'h1);
    for (int k = 0; k < 4; k++) send_byte(0, 8'h00, 0);
    chk("frame_cnt_fs", {24'h0, cnt0}, 32'd2);

    // Payload bits must not combine with fresh bits into a sync match.
    frame0(32'hA5A5A552, 0);
    chk("frame_cnt_pl", {24'h0, cnt0}, 32'd3);
    for (int k = 0; k < 2; k++)
      for (int i = 7; i >= 0; i--) begin
        drv(0, stale[k][i], 1'b1, 1'b0);
        chk("lock_stale", {31'h0, lk0}, 32'h0);
      end

    // Random gaps in i_bit_valid.
    frame0(32'h12345678, 1);
    chk("frame_cnt_gap", {24'h0, cnt0}, 32'd4);
    chk("lock_fall_gap", {31'h0, lk0}, 32'h0);

    // Resync on the 8th bit of byte 2: no 0x34, count unchanged.
    q0.push_back('{8'h12, 1'b1, 1'b0});
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h12, 0);
    for (int i = 7; i >= 1; i--) drv(0, b34[i], 1'b1, 1'b0);
    drv(0, b34[0], 1'b1, 1'b1);
    chk("lock_resync", {31'h0, lk0}, 32'h0);
    chk("frame_cnt_resync", {24'h0, cnt0}, 32'd4);
    drv(0, 1'b0, 1'b0, 1'b0);
    frame0(32'h9ABCDEF0, 0);
    chk("frame_cnt_after", {24'h0, cnt0}, 32'd5);

    // 256 back-to-back single-byte frames: counter wraps to 0.
    for (int f = 0; f < 256; f++) begin
      q1.push_back('{8'(f), 1'b1, 1'b1});
      send_byte(1, 8'hA5, 0);
      send_byte(1, 8'(f), 0);
      chk("wrap_cnt", {24'h0, cnt1}, 32'((f + 1) % 256));
      chk("wrap_lock", {31'h0, lk1}, 32'h0);
    end
    drv(1, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
